vga_fb_arbiter: RTL and testbench

//  Owns the framebuffer write port of the vga driver (write_addr/write_data/write_enable).

---
 rtl/vga_fb_arbiter_if.sv | 48 ++++
 rtl/vga_fb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for the framebuffer write-port arbiter.
// Carries the CPU store handshake, the rectangle-fill command and the
// framebuffer write port toward the vga driver. The slave modport is the
// arbiter itself; the master modport is whoever issues stores and fills.

`ifndef VGA_ADDR_WIDTH
`define VGA_ADDR_WIDTH 18
`endif
`ifndef VGA_DATA_WIDTH
`define VGA_DATA_WIDTH 8
`endif

interface vga_fb_arbiter_if #(
  parameter int ADDR_W = `VGA_ADDR_WIDTH,
  parameter int DATA_W = `VGA_DATA_WIDTH
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_ack;

  logic              fill_start;
  logic [9:0]        fill_x0;
  logic [9:0]        fill_y0;
  logic [9:0]        fill_w;
  logic [9:0]        fill_h;
  logic [DATA_W-1:0] fill_color;
  logic              fill_busy;
  logic              fill_done;

  logic [ADDR_W-1:0] fb_write_addr;
  logic [DATA_W-1:0] fb_write_data;
  logic              fb_write_enable;

  modport master (
    output cpu_req, cpu_addr, cpu_data,
    output fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
    input  cpu_ack, fill_busy, fill_done,
    input  fb_write_addr, fb_write_data, fb_write_enable
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_data,
    input  fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
    output cpu_ack, fill_busy, fill_done,
    output fb_write_addr, fb_write_data, fb_write_enable
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: owns the vga framebuffer write port and shares it between
// CPU single-pixel stores and a clipped rectangle-fill engine, issuing at
// most one framebuffer write per clk50M cycle.
// Optional feature macro: VGA_FB_CPU_PRIO_EN. When defined the CPU always
// wins contention; otherwise the two requesters alternate round-robin.

`ifndef VGA_ADDR_WIDTH
`define VGA_ADDR_WIDTH 18
`endif
`ifndef VGA_DATA_WIDTH
`define VGA_DATA_WIDTH 8
`endif
`ifndef VGA_WIDTH_MULT_SHIFT
`define VGA_WIDTH_MULT_SHIFT 9
`endif

module vga_fb_arbiter #(
  parameter int ADDR_W       = `VGA_ADDR_WIDTH,
  parameter int DATA_W       = `VGA_DATA_WIDTH,
  parameter int STRIDE_SHIFT = `VGA_WIDTH_MULT_SHIFT,
  parameter int FB_WIDTH     = 400,
  parameter int FB_HEIGHT    = 300
) (
  input logic             clk50M,
  input logic             rst_n,
  vga_fb_arbiter_if.slave bus
);

  localparam logic [10:0] FB_W11 = 11'(FB_WIDTH);
  localparam logic [10:0] FB_H11 = 11'(FB_HEIGHT);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} fill_state_t;

  fill_state_t state, next_state;

  logic [9:0]        x0_q, y0_q, w_q, h_q;
  logic [9:0]        cx, cy;
  logic [DATA_W-1:0] color_q;
  logic [10:0]       x_end_q, y_end_q;
  logic [10:0]       sum_x, sum_y, x_end_c, y_end_c;
  logic              empty_rect, last_col, last_px;
  logic              cpu_elig, fill_elig, grant_cpu, grant_fill, accept_start;
  logic [ADDR_W-1:0] fill_addr;

  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_en_q, cpu_ack_q, busy_q, done_q;

`ifndef VGA_FB_CPU_PRIO_EN
  typedef enum logic {RR_CPU, RR_FILL} rr_owner_t;
  rr_owner_t rr_last;
`endif

  // Rectangle geometry: clipped end coordinates, empty test and cursor position
  always_comb begin
    sum_x      = {1'b0, x0_q} + {1'b0, w_q};
    sum_y      = {1'b0, y0_q} + {1'b0, h_q};
    x_end_c    = (sum_x > FB_W11) ? FB_W11 : sum_x;
    y_end_c    = (sum_y > FB_H11) ? FB_H11 : sum_y;
    empty_rect = (w_q == 10'd0) || (h_q == 10'd0) ||
                 ({1'b0, x0_q} >= FB_W11) || ({1'b0, y0_q} >= FB_H11);
    last_col   = ({1'b0, cx} == (x_end_q - 11'd1));
    last_px    = last_col && ({1'b0, cy} == (y_end_q - 11'd1));
    fill_addr  = (ADDR_W'(cy) << STRIDE_SHIFT) + ADDR_W'(cx);
  end

  // Decide who owns the write port this cycle
  always_comb begin
    cpu_elig   = bus.cpu_req && !cpu_ack_q;
    fill_elig  = (state == RUN);
    grant_cpu  = 1'b0;
    grant_fill = 1'b0;
`ifdef VGA_FB_CPU_PRIO_EN
    grant_cpu  = cpu_elig;
    grant_fill = fill_elig && !cpu_elig;
`else
    if (cpu_elig && fill_elig) begin
      grant_cpu  = (rr_last == RR_FILL);
      grant_fill = (rr_last == RR_CPU);
    end else begin
      grant_cpu  = cpu_elig;
      grant_fill = fill_elig;
    end
`endif
  end

  // Fill sequencing: accept a command, qualify it, paint it, report completion
  always_comb begin
    next_state   = state;
    accept_start = bus.fill_start && !busy_q && !done_q;
    case (state)
      IDLE:    if (accept_start) next_state = SETUP;
      SETUP:   next_state = empty_rect ? DONE : RUN;
      RUN:     if (grant_fill && last_px) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Fill state register
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Operand capture and raster cursor; the cursor only moves on granted cycles
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      cx      <= '0;
      cy      <= '0;
    end else begin
      if (state == IDLE && accept_start) begin
        x0_q    <= bus.fill_x0;
        y0_q    <= bus.fill_y0;
        w_q     <= bus.fill_w;
        h_q     <= bus.fill_h;
        color_q <= bus.fill_color;
      end
      if (state == SETUP) begin
        x_end_q <= x_end_c;
        y_end_q <= y_end_c;
        cx      <= x0_q;
        cy      <= y0_q;
      end
      if (state == RUN && grant_fill) begin
        if (last_col) begin
          cx <= x0_q;
          cy <= cy + 10'd1;
        end else begin
          cx <= cx + 10'd1;
        end
      end
    end
  end

  // Registered write port and status; address/data hold when nobody is granted
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      cpu_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q   <= grant_cpu || grant_fill;
      cpu_ack_q <= grant_cpu;
      busy_q    <= (state == SETUP) || (state == RUN);
      done_q    <= (state == DONE);
      if (grant_cpu) begin
        wr_addr_q <= bus.cpu_addr;
        wr_data_q <= bus.cpu_data;
      end else if (grant_fill) begin
        wr_addr_q <= fill_addr;
        wr_data_q <= color_q;
      end
    end
  end

`ifndef VGA_FB_CPU_PRIO_EN
  // Remember the most recent winner so a contended cycle goes to the other side
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n)          rr_last <= RR_FILL;
    else if (grant_cpu)  rr_last <= RR_CPU;
    else if (grant_fill) rr_last <= RR_FILL;
  end
`endif

  assign bus.fb_write_addr   = wr_addr_q;
  assign bus.fb_write_data   = wr_data_q;
  assign bus.fb_write_enable = wr_en_q;
  assign bus.cpu_ack         = cpu_ack_q;
  assign bus.fill_busy       = busy_q;
  assign bus.fill_done       = done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed scenarios plus randomized fills and
// CPU stores. Expected writes are queued per source when issued; a monitor
// pops and compares whenever the write port fires.

module tb_vga_fb_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk50M = 1'b0;
  logic rst_n  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_expected = 0;

  wr_t fill_q[$];
  wr_t cpu_q[$];
  int  fill_cyc[$];
  int  cpu_cyc[$];
  int  done_cyc[$];
  int  busy_cyc[$];

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRIDE_SHIFT(9),
    .FB_WIDTH(400), .FB_HEIGHT(300)
  ) dut (
    .clk50M(clk50M),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 50 MHz clock
  always #10 clk50M = ~clk50M;

  // Cycle counter used to timestamp observed events
  always @(posedge clk50M) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=event expected=none", name);
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  // Reference model: the clipped rectangle as a raster-ordered pixel list
  task automatic model_fill(input int x0, input int y0, input int w, input int h,
                            input int col);
    int  x_end, y_end;
    wr_t p;
    done_expected++;
    if (w == 0 || h == 0 || x0 >= 400 || y0 >= 300) return;
    x_end = (x0 + w > 400) ? 400 : x0 + w;
    y_end = (y0 + h > 300) ? 300 : y0 + h;
    for (int y = y0; y < y_end; y++) begin
      for (int x = x0; x < x_end; x++) begin
        p.addr = ADDR_W'(y * 512 + x);
        p.data = DATA_W'(col);
        fill_q.push_back(p);
      end
    end
  endtask

  // Monitor: every write, ack and done pulse is matched against the scoreboard
  always @(negedge clk50M) begin
    wr_t got, exp_w;
    if (rst_n) begin
      got.addr = bus.fb_write_addr;
      got.data = bus.fb_write_data;
      if (bus.fb_write_enable) begin
        if (bus.cpu_ack) begin
          cpu_cyc.push_back(cyc);
          if (cpu_q.size() == 0) flag_fail("unexpected_cpu_write");
          else begin
            exp_w = cpu_q.pop_front();
            check_output("cpu_write", 32'(got), 32'(exp_w));
          end
        end else begin
          fill_cyc.push_back(cyc);
          if (fill_q.size() == 0) flag_fail("unexpected_fill_write");
          else begin
            exp_w = fill_q.pop_front();
            check_output("fill_write", 32'(got), 32'(exp_w));
          end
        end
      end else if (bus.cpu_ack) begin
        flag_fail("ack_without_write");
      end
      if (bus.fill_busy) busy_cyc.push_back(cyc);
      if (bus.fill_done) begin
        done_cyc.push_back(cyc);
        if (done_expected == 0) flag_fail("unexpected_fill_done");
        else begin
          done_expected--;
          check_output("done_not_busy", 32'(bus.fill_busy), 32'd0);
        end
      end
    end
  end

  task automatic clear_logs();
    fill_cyc.delete();
    cpu_cyc.delete();
    done_cyc.delete();
    busy_cyc.delete();
  endtask

  // Issue one fill command; returns at the negedge after the sampling edge
  task automatic apply_stimulus(input int x0, input int y0, input int w,
                                input int h, input int col, output int n);
    @(negedge clk50M);
    bus.fill_x0    = 10'(x0);
    bus.fill_y0    = 10'(y0);
    bus.fill_w     = 10'(w);
    bus.fill_h     = 10'(h);
    bus.fill_color = DATA_W'(col);
    bus.fill_start = 1'b1;
    model_fill(x0, y0, w, h, col);
    @(posedge clk50M);
    @(negedge clk50M);
    bus.fill_start = 1'b0;
    n = cyc;
  endtask

  // CPU store, called at a negedge; holds the request until the ack is seen
  task automatic cpu_write(input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, output int ack_at);
    wr_t p;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_data = data;
    p.addr = addr;
    p.data = data;
    cpu_q.push_back(p);
    ack_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50M);
      if (bus.cpu_ack) begin
        ack_at = cyc;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    if (ack_at < 0) flag_fail("cpu_ack_timeout");
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50M);
      if (bus.fill_done) return;
    end
    flag_fail("fill_done_timeout");
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk50M);
  endtask

  initial begin
    int n, ack_at, cnt;
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_data   = '0;
    bus.fill_start = 1'b0;
    bus.fill_x0    = '0;
    bus.fill_y0    = '0;
    bus.fill_w     = '0;
    bus.fill_h     = '0;
    bus.fill_color = '0;

    // Reset values
    @(negedge clk50M);
    check_output("rst_enable", 32'(bus.fb_write_enable), 32'd0);
    check_output("rst_addr",   32'(bus.fb_write_addr),   32'd0);
    check_output("rst_data",   32'(bus.fb_write_data),   32'd0);
    check_output("rst_ack",    32'(bus.cpu_ack),         32'd0);
    check_output("rst_busy",   32'(bus.fill_busy),       32'd0);
    check_output("rst_done",   32'(bus.fill_done),       32'd0);
    @(negedge clk50M);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single CPU store with the fill engine idle
    $display("[TB] cpu store");
    clear_logs();
    @(negedge clk50M);
    cpu_write(18'h00205, 8'hE3, ack_at);
    @(negedge clk50M);
    check_output("ack_one_cycle", 32'(bus.cpu_ack), 32'd0);
    idle_cycles(5);
    check_output("cpu_write_count", 32'(cpu_cyc.size()), 32'd1);
    check_output("idle_addr_hold", 32'(bus.fb_write_addr), 32'h00205);
    check_output("idle_data_hold", 32'(bus.fb_write_data), 32'hE3);
    check_output("idle_no_enable", 32'(bus.fb_write_enable), 32'd0);

    // Basic fill with timing, plus a start pulse while busy that must be ignored
    $display("[TB] basic fill");
    clear_logs();
    apply_stimulus(10, 2, 3, 2, 8'h1C, n);
    idle_cycles(2);
    bus.fill_x0 = 10'd0; bus.fill_y0 = 10'd0;
    bus.fill_w = 10'd5;  bus.fill_h = 10'd5;
    bus.fill_start = 1'b1;
    @(negedge clk50M);
    bus.fill_start = 1'b0;
    wait_done(40);
    idle_cycles(3);
    check_output("t2_fill_count", 32'(fill_cyc.size()), 32'd6);
    check_output("t2_first_write", 32'(first_of(fill_cyc)), 32'(n + 2));
    check_output("t2_last_write", 32'(last_of(fill_cyc)), 32'(n + 7));
    check_output("t2_done_cycle", 32'(first_of(done_cyc)), 32'(n + 8));
    check_output("t2_busy_first", 32'(first_of(busy_cyc)), 32'(n + 1));
    check_output("t2_busy_last", 32'(last_of(busy_cyc)), 32'(n + 7));
    check_output("t2_busy_len", 32'(busy_cyc.size()), 32'd7);

    // Clipping at the bottom-right corner
    $display("[TB] clipped fill");
    clear_logs();
    apply_stimulus(398, 299, 5, 4, 8'hFF, n);
    wait_done(40);
    idle_cycles(2);
    check_output("t3_fill_count", 32'(fill_cyc.size()), 32'd2);
    check_output("t3_done_count", 32'(done_cyc.size()), 32'd1);

    // Empty rectangle; a start pulse during fill_done must be ignored
    $display("[TB] empty fill");
    clear_logs();
    apply_stimulus(5, 5, 0, 7, 8'h33, n);
    wait_done(10);
    bus.fill_w = 10'd4; bus.fill_h = 10'd4;
    bus.fill_start = 1'b1;
    @(negedge clk50M);
    bus.fill_start = 1'b0;
    idle_cycles(10);
    check_output("t4_fill_count", 32'(fill_cyc.size()), 32'd0);
    check_output("t4_done_cycle", 32'(first_of(done_cyc)), 32'(n + 2));
    check_output("t4_done_count", 32'(done_cyc.size()), 32'd1);

    // CPU store contending with a running fill
    $display("[TB] contention");
    clear_logs();
    apply_stimulus(10, 2, 3, 2, 8'h1C, n);
    for (int i = 0; i < 10; i++) begin
      if (bus.fb_write_enable) break;
      @(negedge clk50M);
    end
    cpu_write(18'h00000, 8'h55, ack_at);
    wait_done(40);
    idle_cycles(2);
    check_output("t5_cpu_cycle", 32'(first_of(cpu_cyc)), 32'(n + 3));
    check_output("t5_fill_count", 32'(fill_cyc.size()), 32'd6);
    check_output("t5_fill_resume", 32'(last_of(fill_cyc)), 32'(n + 8));
    check_output("t5_done_cycle", 32'(first_of(done_cyc)), 32'(n + 9));

    // Reset in the middle of a fill
    $display("[TB] reset mid-fill");
    clear_logs();
    apply_stimulus(0, 0, 10, 3, 8'hA5, n);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 3; i++) begin
      if (bus.fb_write_enable) cnt++;
      if (cnt < 3) @(negedge clk50M);
    end
    check_output("t6_writes_before_reset", 32'(cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    check_output("t6_async_enable", 32'(bus.fb_write_enable), 32'd0);
    check_output("t6_async_addr",   32'(bus.fb_write_addr),   32'd0);
    check_output("t6_async_data",   32'(bus.fb_write_data),   32'd0);
    check_output("t6_async_busy",   32'(bus.fill_busy),       32'd0);
    fill_q.delete();
    done_expected = 0;
    idle_cycles(2);
    rst_n = 1'b1;
    clear_logs();
    idle_cycles(40);
    check_output("t6_no_writes_after", 32'(fill_cyc.size()), 32'd0);
    check_output("t6_no_done_after", 32'(done_cyc.size()), 32'd0);

    // Randomized fills with independent CPU traffic
    $display("[TB] random traffic");
    fork
      begin
        int rn, x0, y0, w, h;
        for (int k = 0; k < 14; k++) begin
          x0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(388, 405)) : int'($urandom_range(0, 30));
          y0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(294, 303)) : int'($urandom_range(0, 30));
          w  = int'($urandom_range(0, 8));
          h  = int'($urandom_range(0, 4));
          apply_stimulus(x0, y0, w, h, int'($urandom_range(0, 255)), rn);
          wait_done(200);
          idle_cycles(int'($urandom_range(0, 3)));
        end
      end
      begin
        int ra;
        for (int k = 0; k < 16; k++) begin
          idle_cycles(int'($urandom_range(1, 10)));
          cpu_write(ADDR_W'($urandom_range(0, 262143)), DATA_W'($urandom_range(0, 255)), ra);
        end
      end
    join
    idle_cycles(5);

    check_output("end_fill_queue_empty", 32'(fill_q.size()), 32'd0);
    check_output("end_cpu_queue_empty", 32'(cpu_q.size()), 32'd0);
    check_output("end_done_balance", 32'(done_expected), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
